// File: rtl/output_memory_writer.sv
// -----------------------------------------------------------------------------
// output_memory_writer
//
// Takes one NxN tile of signed accumulator results from the processor array,
// saturates every element down to DATA_WIDTH and streams the tile into C
// memory as row-major beats of P consecutive elements.
//
// A tile transaction is: accept a base address + row stride (IDLE), accept the
// result tile (WAIT_RESULT), then emit N*N/P write beats (WRITE). Beat (r,b)
// goes to base + r*stride + b*P (modulo 2^MEMORY_ADDRESS_BITS).
//
// Ports
//   clk                  : clock, all state changes on its rising edge
//   reset                : asynchronous active-high reset
//   address_valid/ready  : handshake for the C tile base address
//   address_input        : element address of tile element [0][0]
//   stride_input         : element distance between consecutive tile rows
//   result_valid/ready   : handshake for the finished result tile
//   result_data          : flat tile, element [r][c] at bits
//                          (r*N+c)*ACCUM_DATA_WIDTH +: ACCUM_DATA_WIDTH (signed)
//   memory_write_valid   : a write beat is presented to C memory
//   memory_write_ready   : C memory accepts the beat
//   memory_write_address : address of beat element 0
//   memory_write_data    : element j at bits j*DATA_WIDTH +: DATA_WIDTH,
//                          destined for address memory_write_address + j
//   busy                 : high whenever the FSM is not IDLE
//   tile_done            : one-cycle pulse after the last beat is accepted
//
// N must be a multiple of PARALLEL_DATA_STREAMING_SIZE and ACCUM_DATA_WIDTH
// must be at least DATA_WIDTH.
// -----------------------------------------------------------------------------
module output_memory_writer #(
    parameter int DATA_WIDTH                   = 8,
    parameter int N                            = 4,
    parameter int ACCUM_DATA_WIDTH             = 16,
    parameter int MEMORY_ADDRESS_BITS          = 64,
    parameter int PARALLEL_DATA_STREAMING_SIZE = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         address_valid,
    output logic                                         address_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0]               address_input,
    input  logic [MEMORY_ADDRESS_BITS-1:0]               stride_input,
    input  logic                                         result_valid,
    output logic                                         result_ready,
    input  logic [N*N*ACCUM_DATA_WIDTH-1:0]              result_data,
    output logic                                         memory_write_valid,
    input  logic                                         memory_write_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0]               memory_write_address,
    output logic [PARALLEL_DATA_STREAMING_SIZE*DATA_WIDTH-1:0] memory_write_data,
    output logic                                         busy,
    output logic                                         tile_done
);

    localparam int P       = PARALLEL_DATA_STREAMING_SIZE;
    localparam int CHUNKS  = N / P;
    localparam int ROW_W   = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int TILE_W  = N * N * ACCUM_DATA_WIDTH;
    localparam int BEAT_W  = P * DATA_WIDTH;

    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(N - 1);
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
    localparam logic [MEMORY_ADDRESS_BITS-1:0] CHUNK_STEP = MEMORY_ADDRESS_BITS'(P);

    // Saturation bounds expressed at accumulator width so the compare is
    // a plain signed compare with no extension games.
    localparam logic signed [ACCUM_DATA_WIDTH-1:0] SAT_MAX =
        {{(ACCUM_DATA_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUM_DATA_WIDTH-1:0] SAT_MIN =
        {{(ACCUM_DATA_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_RESULT = 2'd1,
        WRITE       = 2'd2
    } state_t;

    // Clamp one accumulator value into the signed DATA_WIDTH range.
    function automatic logic [DATA_WIDTH-1:0] saturate(
        input logic signed [ACCUM_DATA_WIDTH-1:0] value
    );
        logic [DATA_WIDTH-1:0] result;
        if (value > SAT_MAX) begin
            result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (value < SAT_MIN) begin
            result = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            result = value[DATA_WIDTH-1:0];
        end
        return result;
    endfunction

    // Build the saturated beat for row 'row', chunk 'chunk' of a tile.
    function automatic logic [BEAT_W-1:0] beat_data(
        input logic [TILE_W-1:0] tile,
        input int                row,
        input int                chunk
    );
        logic [BEAT_W-1:0] beat;
        beat = '0;
        for (int j = 0; j < P; j++) begin
            beat[j*DATA_WIDTH +: DATA_WIDTH] =
                saturate(tile[((row * N) + (chunk * P) + j) * ACCUM_DATA_WIDTH +: ACCUM_DATA_WIDTH]);
        end
        return beat;
    endfunction

    state_t                          state_r, state_s;
    logic [MEMORY_ADDRESS_BITS-1:0]  base_r, base_s;
    logic [MEMORY_ADDRESS_BITS-1:0]  stride_r, stride_s;
    logic [TILE_W-1:0]               tile_r, tile_s;
    logic [ROW_W-1:0]                row_r, row_s;
    logic [CHUNK_W-1:0]              chunk_r, chunk_s;
    // Address of chunk 0 of the current row; stepping it by stride avoids
    // a multiplier for r*stride.
    logic [MEMORY_ADDRESS_BITS-1:0]  row_base_r, row_base_s;
    logic [MEMORY_ADDRESS_BITS-1:0]  addr_r, addr_s;
    logic [BEAT_W-1:0]               data_r, data_s;
    logic                            done_r, done_s;

    // Handshake outputs are pure decodes of the state register.
    assign address_ready        = (state_r == IDLE);
    assign result_ready         = (state_r == WAIT_RESULT);
    assign memory_write_valid   = (state_r == WRITE);
    assign busy                 = (state_r != IDLE);
    assign memory_write_address = addr_r;
    assign memory_write_data    = data_r;
    assign tile_done            = done_r;

    // Next-state and next-register computation for the whole writer.
    always_comb begin
        state_s    = state_r;
        base_s     = base_r;
        stride_s   = stride_r;
        tile_s     = tile_r;
        row_s      = row_r;
        chunk_s    = chunk_r;
        row_base_s = row_base_r;
        addr_s     = addr_r;
        data_s     = data_r;
        done_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (address_valid) begin
                    base_s   = address_input;
                    stride_s = stride_input;
                    state_s  = WAIT_RESULT;
                end else begin
                    state_s  = IDLE;
                end
            end

            WAIT_RESULT: begin
                if (result_valid) begin
                    // Beat (0,0) is prepared straight from the input bus so it
                    // is valid the cycle after capture.
                    tile_s     = result_data;
                    row_s      = '0;
                    chunk_s    = '0;
                    row_base_s = base_r;
                    addr_s     = base_r;
                    data_s     = beat_data(result_data, 0, 0);
                    state_s    = WRITE;
                end else begin
                    state_s    = WAIT_RESULT;
                end
            end

            WRITE: begin
                if (memory_write_ready) begin
                    if ((row_r == LAST_ROW) && (chunk_r == LAST_CHUNK)) begin
                        row_s   = '0;
                        chunk_s = '0;
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else if (chunk_r == LAST_CHUNK) begin
                        row_s      = row_r + ROW_W'(1);
                        chunk_s    = '0;
                        row_base_s = row_base_r + stride_r;
                        addr_s     = row_base_r + stride_r;
                        data_s     = beat_data(tile_r, int'(row_r) + 1, 0);
                        state_s    = WRITE;
                    end else begin
                        chunk_s = chunk_r + CHUNK_W'(1);
                        addr_s  = addr_r + CHUNK_STEP;
                        data_s  = beat_data(tile_r, int'(row_r), int'(chunk_r) + 1);
                        state_s = WRITE;
                    end
                end else begin
                    // Stalled: address and data registers simply hold.
                    state_s = WRITE;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any tile in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            base_r     <= '0;
            stride_r   <= '0;
            tile_r     <= '0;
            row_r      <= '0;
            chunk_r    <= '0;
            row_base_r <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            base_r     <= base_s;
            stride_r   <= stride_s;
            tile_r     <= tile_s;
            row_r      <= row_s;
            chunk_r    <= chunk_s;
            row_base_r <= row_base_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            done_r     <= done_s;
        end
    end

endmodule

// File: tb/tb_output_memory_writer.sv
// -----------------------------------------------------------------------------
// tb_output_memory_writer
//
// Directed, table-driven bench for output_memory_writer with default
// parameters (8-bit C elements, 4x4 tile, 16-bit accumulators, 64-bit
// addresses, 4 elements per beat). Each table record holds a base address,
// stride, tile and the hand-computed beat addresses and data. Separate
// sequences cover write stalls, an early result offer and mid-tile reset.
// -----------------------------------------------------------------------------
module tb_output_memory_writer;

    logic         clk;
    logic         reset;
    logic         address_valid;
    logic         address_ready;
    logic [63:0]  address_input;
    logic [63:0]  stride_input;
    logic         result_valid;
    logic         result_ready;
    logic [255:0] result_data;
    logic         memory_write_valid;
    logic         memory_write_ready;
    logic [63:0]  memory_write_address;
    logic [31:0]  memory_write_data;
    logic         busy;
    logic         tile_done;

    int checks;
    int errors;

    typedef struct packed {
        logic [63:0]       base;
        logic [63:0]       stride;
        logic [255:0]      tile;
        logic [3:0][63:0]  exp_addr;
        logic [3:0][31:0]  exp_data;
    } vec_t;

    vec_t vecs [3];

    output_memory_writer dut (
        .clk                  (clk),
        .reset                (reset),
        .address_valid        (address_valid),
        .address_ready        (address_ready),
        .address_input        (address_input),
        .stride_input         (stride_input),
        .result_valid         (result_valid),
        .result_ready         (result_ready),
        .result_data          (result_data),
        .memory_write_valid   (memory_write_valid),
        .memory_write_ready   (memory_write_ready),
        .memory_write_address (memory_write_address),
        .memory_write_data    (memory_write_data),
        .busy                 (busy),
        .tile_done            (tile_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tile row of four signed 16-bit results, column c at bits c*16.
    function automatic logic [63:0] row4(input int c0, input int c1, input int c2, input int c3);
        logic [63:0] r;
        r[15:0]  = 16'(c0);
        r[31:16] = 16'(c1);
        r[47:32] = 16'(c2);
        r[63:48] = 16'(c3);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_beat(input int k, input logic [63:0] ea, input logic [31:0] ed);
        check($sformatf("beat%0d valid", k), 64'(memory_write_valid), 64'd1);
        check($sformatf("beat%0d addr", k), memory_write_address, ea);
        check($sformatf("beat%0d data", k), 64'(memory_write_data), 64'(ed));
        check($sformatf("beat%0d tile_done", k), 64'(tile_done), 64'd0);
    endtask

    // Runs a whole tile starting at a negedge with the writer IDLE.
    // Beat stall_beat is held off for stall_cycles cycles with ready low.
    task automatic run_tile(input vec_t v, input int stall_beat, input int stall_cycles);
        address_valid      = 1'b1;
        address_input      = v.base;
        stride_input       = v.stride;
        result_valid       = 1'b1;
        result_data        = v.tile;
        memory_write_ready = 1'b1;
        check("addr_ready idle", 64'(address_ready), 64'd1);
        check("result_ready idle", 64'(result_ready), 64'd0);
        @(negedge clk);
        address_valid = 1'b0;
        address_input = 64'hDEAD_BEEF_DEAD_BEEF;
        check("result_ready wait", 64'(result_ready), 64'd1);
        check("busy wait", 64'(busy), 64'd1);
        check("valid wait", 64'(memory_write_valid), 64'd0);
        @(negedge clk);
        result_valid = 1'b0;
        result_data  = {4{row4(-1, -1, -1, -1)}};
        for (int k = 0; k < 4; k++) begin
            if (k == stall_beat) begin
                memory_write_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    check_beat(k, v.exp_addr[k], v.exp_data[k]);
                    @(negedge clk);
                end
                memory_write_ready = 1'b1;
            end
            check_beat(k, v.exp_addr[k], v.exp_data[k]);
            @(negedge clk);
        end
        check("end valid", 64'(memory_write_valid), 64'd0);
        check("end tile_done", 64'(tile_done), 64'd1);
        check("end addr_ready", 64'(address_ready), 64'd1);
        check("end busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("tile_done pulse", 64'(tile_done), 64'd0);
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        reset              = 1'b1;
        address_valid      = 1'b0;
        address_input      = '0;
        stride_input       = '0;
        result_valid       = 1'b0;
        result_data        = '0;
        memory_write_ready = 1'b1;

        // Basic tile: result[r][c] = r*4+c.
        vecs[0].base     = 64'd100;
        vecs[0].stride   = 64'd16;
        vecs[0].tile     = {row4(12, 13, 14, 15), row4(8, 9, 10, 11), row4(4, 5, 6, 7), row4(0, 1, 2, 3)};
        vecs[0].exp_addr = {64'd148, 64'd132, 64'd116, 64'd100};
        vecs[0].exp_data = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
        // Saturation corners.
        vecs[1].base     = 64'd1000;
        vecs[1].stride   = 64'd100;
        vecs[1].tile     = {row4(32767, -32768, 126, -127), row4(1000, -1000, 0, 1),
                            row4(-129, 128, -1, -128), row4(300, -200, -5, 127)};
        vecs[1].exp_addr = {64'd1300, 64'd1200, 64'd1100, 64'd1000};
        vecs[1].exp_data = {32'h817E807F, 32'h0100807F, 32'h80FF7F80, 32'h7FFB807F};
        // Address wrap at 2^64.
        vecs[2].base     = 64'hFFFF_FFFF_FFFF_FFFE;
        vecs[2].stride   = 64'd4;
        vecs[2].tile     = vecs[0].tile;
        vecs[2].exp_addr = {64'd10, 64'd6, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2].exp_data = vecs[0].exp_data;

        // Reset state.
        #12;
        check("rst addr_ready", 64'(address_ready), 64'd1);
        check("rst result_ready", 64'(result_ready), 64'd0);
        check("rst valid", 64'(memory_write_valid), 64'd0);
        check("rst tile_done", 64'(tile_done), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst addr", memory_write_address, 64'd0);
        check("rst data", 64'(memory_write_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            run_tile(vecs[i], -1, 0);
        end

        // Stall beat 1 for three cycles: four identical observations.
        run_tile(vecs[0], 1, 3);

        // Result offered before the address: must not be captured.
        result_valid = 1'b1;
        result_data  = vecs[0].tile;
        for (int s = 0; s < 5; s++) begin
            check("early result_ready", 64'(result_ready), 64'd0);
            @(negedge clk);
        end
        check("early result_ready", 64'(result_ready), 64'd0);
        address_valid = 1'b1;
        address_input = 64'd500;
        stride_input  = 64'd8;
        @(negedge clk);
        address_valid = 1'b0;
        check("late result_ready", 64'(result_ready), 64'd1);
        check("late valid", 64'(memory_write_valid), 64'd0);
        @(negedge clk);
        result_valid = 1'b0;
        check_beat(0, 64'd500, 32'h03020100);
        @(negedge clk);
        check_beat(1, 64'd508, 32'h07060504);
        @(negedge clk);
        check_beat(2, 64'd516, 32'h0B0A0908);
        @(negedge clk);
        check_beat(3, 64'd524, 32'h0F0E0D0C);
        @(negedge clk);
        check("late tile_done", 64'(tile_done), 64'd1);
        @(negedge clk);

        // Reset pulsed while beat 2 is presented.
        address_valid = 1'b1;
        address_input = 64'd100;
        stride_input  = 64'd16;
        result_valid  = 1'b1;
        result_data   = vecs[0].tile;
        @(negedge clk);
        address_valid = 1'b0;
        @(negedge clk);
        result_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_beat(2, 64'd132, 32'h0B0A0908);
        #2;
        reset = 1'b1;
        #1;
        check("abort valid", 64'(memory_write_valid), 64'd0);
        check("abort addr_ready", 64'(address_ready), 64'd1);
        check("abort busy", 64'(busy), 64'd0);
        check("abort addr", memory_write_address, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        check("post-rst valid", 64'(memory_write_valid), 64'd0);
        @(negedge clk);
        check("post-rst valid", 64'(memory_write_valid), 64'd0);
        check("post-rst tile_done", 64'(tile_done), 64'd0);
        vecs[0].base     = 64'd0;
        vecs[0].stride   = 64'd4;
        vecs[0].exp_addr = {64'd12, 64'd8, 64'd4, 64'd0};
        run_tile(vecs[0], -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
